// File: rtl/hrv_rr_scheduler.sv
// hrv_rr_scheduler
// Shares one RMSSD engine between two RR-interval channels. Each channel
// owns a private FIFO; when a FIFO holds at least one full window the channel
// becomes eligible. A round-robin arbiter then hands the engine one job:
// a start pulse, WINDOW consecutive samples, and a wait for the done pulse
// (or a timeout). The result is returned tagged with its channel.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   chX_rr/valid/ready    per-channel sample push interface (X = 0, 1)
//   eng_start             one-cycle pulse, engine clears its accumulator
//   eng_valid, eng_rr     sample stream into the engine
//   eng_done, eng_rmssd   engine result pulse and value
//   res_valid/ready       result handshake towards the consumer
//   res_ch, res_rmssd     result channel tag and value (0 on abort)
//   res_err               job aborted by timeout
//   busy                  scheduler FSM not idle
module hrv_rr_scheduler #(
  parameter int RR_W    = 8,
  parameter int WINDOW  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RR_W-1:0] ch0_rr,
  input  logic            ch0_valid,
  output logic            ch0_ready,
  input  logic [RR_W-1:0] ch1_rr,
  input  logic            ch1_valid,
  output logic            ch1_ready,
  output logic            eng_start,
  output logic            eng_valid,
  output logic [RR_W-1:0] eng_rr,
  input  logic            eng_done,
  input  logic [7:0]      eng_rmssd,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_ch,
  output logic [7:0]      res_rmssd,
  output logic            res_err,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + WINDOW);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] WIN_C     = CW'(WINDOW);
  localparam logic [TW-1:0] FEED_LAST = TW'(WINDOW - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_RESULT} state_t;

  state_t          state_q, state_d;
  logic [RR_W-1:0] mem0_q [DEPTH];
  logic [RR_W-1:0] mem1_q [DEPTH];
  logic [AW-1:0]   wr0_q, wr0_d, rd0_q, rd0_d;
  logic [AW-1:0]   wr1_q, wr1_d, rd1_q, rd1_d;
  logic [CW-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic            push0, push1, pop0, pop1;
  logic            elig0, elig1, grant;
  logic            gnt_q, gnt_d, rr_last_q, rr_last_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            eng_start_q, eng_start_d, eng_valid_q, eng_valid_d;
  logic [RR_W-1:0] eng_rr_q, eng_rr_d;
  logic            res_ch_q, res_ch_d, res_err_q, res_err_d;
  logic [7:0]      res_rmssd_q, res_rmssd_d;

  // Ready depends only on the current count, so a full FIFO refuses a push
  // even in a cycle where the engine pops from it.
  assign ch0_ready = (cnt0_q != DEPTH_C);
  assign ch1_ready = (cnt1_q != DEPTH_C);
  assign push0     = ch0_valid & ch0_ready;
  assign push1     = ch1_valid & ch1_ready;
  assign pop0      = (state_q == S_FEED) & ~gnt_q;
  assign pop1      = (state_q == S_FEED) & gnt_q;
  assign elig0     = (cnt0_q >= WIN_C);
  assign elig1     = (cnt1_q >= WIN_C);
  // Only one eligible: take it. Both eligible: take the one not served last.
  assign grant     = (elig0 & elig1) ? ~rr_last_q : elig1;

  always_comb begin
    wr0_d  = wr0_q;
    rd0_d  = rd0_q;
    cnt0_d = cnt0_q;
    wr1_d  = wr1_q;
    rd1_d  = rd1_q;
    cnt1_d = cnt1_q;
    if (push0) wr0_d = wr0_q + AW'(1);
    if (pop0)  rd0_d = rd0_q + AW'(1);
    if (push1) wr1_d = wr1_q + AW'(1);
    if (pop1)  rd1_d = rd1_q + AW'(1);
    case ({push0, pop0})
      2'b10:   cnt0_d = cnt0_q + CW'(1);
      2'b01:   cnt0_d = cnt0_q - CW'(1);
      default: cnt0_d = cnt0_q;
    endcase
    case ({push1, pop1})
      2'b10:   cnt1_d = cnt1_q + CW'(1);
      2'b01:   cnt1_d = cnt1_q - CW'(1);
      default: cnt1_d = cnt1_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    tcnt_d      = tcnt_q;
    eng_start_d = 1'b0;
    eng_valid_d = 1'b0;
    eng_rr_d    = eng_rr_q;
    res_ch_d    = res_ch_q;
    res_err_d   = res_err_q;
    res_rmssd_d = res_rmssd_q;
    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          gnt_d     = grant;
          rr_last_d = grant;
          state_d   = S_START;
        end
      end
      S_START: begin
        eng_start_d = 1'b1;
        tcnt_d      = '0;
        state_d     = S_FEED;
      end
      S_FEED: begin
        // The head popped this cycle reaches the engine one cycle later,
        // so the sample stream trails the start pulse by exactly one cycle.
        eng_valid_d = 1'b1;
        eng_rr_d    = gnt_q ? mem1_q[rd1_q] : mem0_q[rd0_q];
        if (tcnt_q == FEED_LAST) begin
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          res_ch_d    = gnt_q;
          res_rmssd_d = eng_rmssd;
          res_err_d   = 1'b0;
          state_d     = S_RESULT;
        end else if (tcnt_q == TO_LAST) begin
          res_ch_d    = gnt_q;
          res_rmssd_d = 8'd0;
          res_err_d   = 1'b1;
          state_d     = S_RESULT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr0_q       <= '0;
      rd0_q       <= '0;
      cnt0_q      <= '0;
      wr1_q       <= '0;
      rd1_q       <= '0;
      cnt1_q      <= '0;
      gnt_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      tcnt_q      <= '0;
      eng_start_q <= 1'b0;
      eng_valid_q <= 1'b0;
      eng_rr_q    <= '0;
      res_ch_q    <= 1'b0;
      res_err_q   <= 1'b0;
      res_rmssd_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr0_q       <= wr0_d;
      rd0_q       <= rd0_d;
      cnt0_q      <= cnt0_d;
      wr1_q       <= wr1_d;
      rd1_q       <= rd1_d;
      cnt1_q      <= cnt1_d;
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      tcnt_q      <= tcnt_d;
      eng_start_q <= eng_start_d;
      eng_valid_q <= eng_valid_d;
      eng_rr_q    <= eng_rr_d;
      res_ch_q    <= res_ch_d;
      res_err_q   <= res_err_d;
      res_rmssd_q <= res_rmssd_d;
    end
  end

  // Sample storage carries no reset; emptiness is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push0) mem0_q[wr0_q] <= ch0_rr;
    if (push1) mem1_q[wr1_q] <= ch1_rr;
  end

  assign eng_start = eng_start_q;
  assign eng_valid = eng_valid_q;
  assign eng_rr    = eng_rr_q;
  assign res_valid = (state_q == S_RESULT);
  assign res_ch    = res_ch_q;
  assign res_rmssd = res_rmssd_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hrv_rr_scheduler.sv
// Directed bench for hrv_rr_scheduler: single-channel job, round-robin
// alternation, FIFO full behaviour, engine timeout, result back-pressure and
// reset in the middle of a job. The engine is modelled by hand in the steps.
module tb_hrv_rr_scheduler;

  localparam int WINDOW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ch0_rr, ch1_rr;
  logic       ch0_valid, ch1_valid, ch0_ready, ch1_ready;
  logic       eng_start, eng_valid, eng_done;
  logic [7:0] eng_rr, eng_rmssd;
  logic       res_valid, res_ready, res_ch, res_err, busy;
  logic [7:0] res_rmssd;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] expv [WINDOW];
  logic       first_rdy1;
  int         saw;
  int         n;

  hrv_rr_scheduler #(.RR_W(8), .WINDOW(8), .DEPTH(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .ch0_rr(ch0_rr), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .ch1_rr(ch1_rr), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .eng_start(eng_start), .eng_valid(eng_valid), .eng_rr(eng_rr),
    .eng_done(eng_done), .eng_rmssd(eng_rmssd),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_rmssd(res_rmssd), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] v);
    ch0_valid = 1'b1;
    ch0_rr    = v;
    tick();
    ch0_valid = 1'b0;
  endtask

  task automatic push1(input logic [7:0] v);
    ch1_valid = 1'b1;
    ch1_rr    = v;
    tick();
    ch1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k;
    k = 0;
    while (eng_start !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_start"}, 32'(eng_start), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  task automatic feed(input string tag);
    for (int i = 0; i < WINDOW; i++) begin
      tick();
      if (i == 0) begin
        first_rdy1 = ch1_ready;
        chk({tag, "_start_pulse"}, 32'(eng_start), 0);
      end
      chk($sformatf("%s_valid%0d", tag, i), 32'(eng_valid), 1);
      chk($sformatf("%s_rr%0d", tag, i), 32'(eng_rr), 32'(expv[i]));
    end
    tick();
    chk({tag, "_valid_end"}, 32'(eng_valid), 0);
  endtask

  task automatic done_after(input int cyc, input logic [7:0] val);
    repeat (cyc) tick();
    eng_done  = 1'b1;
    eng_rmssd = val;
    tick();
    eng_done  = 1'b0;
  endtask

  task automatic accept(input string tag, input logic ch, input logic [7:0] rm, input logic err);
    chk({tag, "_res_valid"}, 32'(res_valid), 1);
    chk({tag, "_res_ch"}, 32'(res_ch), 32'(ch));
    chk({tag, "_res_rmssd"}, 32'(res_rmssd), 32'(rm));
    chk({tag, "_res_err"}, 32'(res_err), 32'(err));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_res_drop"}, 32'(res_valid), 0);
  endtask

  task automatic quiet(input string tag, input int cyc);
    int seen;
    seen = 0;
    repeat (cyc) begin
      tick();
      if (eng_start === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 0);
  endtask

  initial begin
    rst = 1'b1; ch0_rr = '0; ch1_rr = '0; ch0_valid = 1'b0; ch1_valid = 1'b0;
    eng_done = 1'b0; eng_rmssd = '0; res_ready = 1'b0;
    do_reset();
    chk("rst_ch0_ready", 32'(ch0_ready), 1);
    chk("rst_ch1_ready", 32'(ch1_ready), 1);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_eng_valid", 32'(eng_valid), 0);
    chk("rst_eng_rr", 32'(eng_rr), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_fields", 32'({res_ch, res_err, res_rmssd}), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: single ch0 job
    expv = '{8'd100, 8'd104, 8'd98, 8'd102, 8'd100, 8'd105, 8'd99, 8'd101};
    for (int i = 0; i < WINDOW; i++) push0(expv[i]);
    wait_start("t1", 20);
    feed("t1");
    done_after(8, 8'h05);
    chk("t1_res_valid_early", 32'(res_valid), 1);
    repeat (3) tick();
    accept("t1", 1'b0, 8'd5, 1'b0);
    quiet("t1_no_extra_job", 10);

    // 2: strict alternation starting with ch0 after reset
    do_reset();
    for (int i = 0; i < WINDOW; i++) begin
      ch0_valid = 1'b1; ch0_rr = 8'(10 + i);
      ch1_valid = 1'b1; ch1_rr = 8'(50 + i);
      tick();
    end
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(10 + i);
    wait_start("t2a", 20); feed("t2a"); done_after(1, 8'h11); accept("t2a", 1'b0, 8'h11, 1'b0);
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(50 + i);
    wait_start("t2b", 20); feed("t2b"); done_after(1, 8'h22); accept("t2b", 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < WINDOW; i++) begin
      ch0_valid = 1'b1; ch0_rr = 8'(20 + i);
      ch1_valid = 1'b1; ch1_rr = 8'(70 + i);
      tick();
    end
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(20 + i);
    wait_start("t2c", 20); feed("t2c"); done_after(1, 8'h33); accept("t2c", 1'b0, 8'h33, 1'b0);
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(70 + i);
    wait_start("t2d", 20); feed("t2d"); done_after(1, 8'h44); accept("t2d", 1'b1, 8'h44, 1'b0);

    // 3 + 5: ch0 result held back while ch1 FIFO fills to the brim
    do_reset();
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(1 + i);
    for (int i = 0; i < WINDOW; i++) push0(expv[i]);
    wait_start("t3a", 20); feed("t3a"); done_after(2, 8'h07);
    saw = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_ready_before%0d", i), 32'(ch1_ready), 1);
      push1(8'(200 + i));
      if (eng_start === 1'b1) saw++;
    end
    chk("t3_ready_full", 32'(ch1_ready), 0);
    push1(8'hEE);
    chk("t3_ready_still_full", 32'(ch1_ready), 0);
    repeat (4) begin
      tick();
      if (eng_start === 1'b1) saw++;
    end
    chk("t5_no_start_while_held", 32'(saw), 0);
    chk("t5_busy_held", 32'(busy), 1);
    accept("t5", 1'b0, 8'h07, 1'b0);
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(200 + i);
    wait_start("t3b", 20);
    chk("t3_ready_before_pop", 32'(ch1_ready), 0);
    feed("t3b");
    chk("t3_ready_after_pop", 32'(first_rdy1), 1);
    done_after(1, 8'h09); accept("t3b", 1'b1, 8'h09, 1'b0);
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(208 + i);
    wait_start("t3c", 20); feed("t3c"); done_after(1, 8'h0A); accept("t3c", 1'b1, 8'h0A, 1'b0);
    quiet("t3_17th_not_stored", 30);

    // 4: engine never answers
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(30 + i);
    for (int i = 0; i < WINDOW; i++) push0(expv[i]);
    wait_start("t4", 20); feed("t4");
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 63);
    accept("t4", 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(40 + i);
    for (int i = 0; i < WINDOW; i++) push1(expv[i]);
    wait_start("t4r", 20); feed("t4r"); done_after(3, 8'h21); accept("t4r", 1'b1, 8'h21, 1'b0);

    // 6: reset in the middle of FEED
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(90 + i);
    for (int i = 0; i < WINDOW; i++) push0(expv[i]);
    wait_start("t6", 20);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_rr%0d", i), 32'(eng_rr), 32'(expv[i]));
    end
    rst = 1'b1;
    tick();
    chk("t6_valid_low", 32'(eng_valid), 0);
    chk("t6_start_low", 32'(eng_start), 0);
    chk("t6_busy_low", 32'(busy), 0);
    chk("t6_ch0_ready", 32'(ch0_ready), 1);
    rst = 1'b0;
    eng_done = 1'b1; eng_rmssd = 8'h55;
    tick();
    eng_done = 1'b0;
    chk("t6_spurious_done_res", 32'(res_valid), 0);
    chk("t6_spurious_done_busy", 32'(busy), 0);
    quiet("t6_fifo_emptied", 20);
    for (int i = 0; i < WINDOW; i++) expv[i] = 8'(120 + i);
    for (int i = 0; i < WINDOW; i++) push0(expv[i]);
    wait_start("t6n", 20); feed("t6n"); done_after(1, 8'h0B); accept("t6n", 1'b0, 8'h0B, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
